// File: rtl/axis_dma_pkg.sv
// Shared definitions for the DMA stream writer and the memory read-back checker.
//   ByteW    : width of one stream/memory byte lane.
//   BeatCntW : width of the beat counter port (holds COUNT up to 2^16).
//   dma_state_e : writer FSM states.
package axis_dma_pkg;

  localparam int unsigned ByteW    = 8;
  localparam int unsigned BeatCntW = 17;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } dma_state_e;

endpackage

// File: rtl/axis_s2mm_bytewriter.sv
// Stream-to-memory byte writer.
// Accepts COUNT bytes from an 8-bit AXI-Stream and writes them to consecutive byte
// addresses starting at base_addr, then pulses done once the last write is accepted.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, base_addr    : launch a transfer (IDLE only), first write address
//   s_axis_*            : 8-bit input stream (tdata/tvalid/tready/tlast)
//   wr_en/addr/data     : registered memory write request, accepted on wr_en && wr_ready
//   busy, done          : transfer in progress, one-cycle completion pulse
//   err_early_last      : tlast seen before the final beat (sticky until next start)
//   err_no_last         : final beat arrived without tlast (sticky until next start)
//   beat_count          : beats accepted in the current/last transfer
module axis_s2mm_bytewriter
  import axis_dma_pkg::*;
#(
  parameter int unsigned COUNT  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ByteW-1:0]    s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [ByteW-1:0]    wr_data,
  input  logic                wr_ready,
  output logic                busy,
  output logic                done,
  output logic                err_early_last,
  output logic                err_no_last,
  output logic [BeatCntW-1:0] beat_count
);

  localparam logic [BeatCntW-1:0] LastIdx = BeatCntW'(COUNT - 1);

  dma_state_e state_q, state_d;

  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ByteW-1:0]    wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic                err_early_q, err_early_d;
  logic                err_no_q, err_no_d;
  logic [BeatCntW-1:0] beat_count_q, beat_count_d;

  logic beat_acc;
  logic wr_acc;

  assign wr_acc = wr_en_q && wr_ready;

  // The output register accepts a new byte when empty or emptying this cycle;
  // tready depends only on state and wr_ready, never on tvalid.
  assign s_axis_tready = (state_q == StRun) && (!wr_en_q || wr_ready);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = wr_en_q;
    done_d       = 1'b0;
    err_early_d  = err_early_q;
    err_no_d     = err_no_q;
    beat_count_d = beat_count_q;

    if (wr_acc) begin
      wr_en_d = 1'b0;
    end

    // A new beat reloads the output register; addresses wrap modulo 2^ADDR_W.
    if (beat_acc) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = base_q + ADDR_W'(beat_count_q);
      wr_data_d    = s_axis_tdata;
      beat_count_d = beat_count_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          state_d      = StRun;
          base_d       = base_addr;
          beat_count_d = '0;
          err_early_d  = 1'b0;
          err_no_d     = 1'b0;
        end
      end
      StRun: begin
        if (beat_acc) begin
          if (beat_count_q == LastIdx) begin
            err_no_d = !s_axis_tlast;
            state_d  = StDrain;
          end else if (s_axis_tlast) begin
            err_early_d = 1'b1;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        if (!wr_en_q || wr_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      err_early_q  <= 1'b0;
      err_no_q     <= 1'b0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
      err_early_q  <= err_early_d;
      err_no_q     <= err_no_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign err_early_last = err_early_q;
  assign err_no_last    = err_no_q;
  assign beat_count     = beat_count_q;

endmodule

// File: tb/tb_axis_s2mm_bytewriter.sv
// Self-checking bench for axis_s2mm_bytewriter: random stream bytes, directed
// framing/backpressure/wrap/reset scenarios, expected writes built by a simple
// stream-walking reference model.
module tb_axis_s2mm_bytewriter;

  localparam int unsigned COUNT  = 32;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic              err_early_last;
  logic              err_no_last;
  logic [16:0]       beat_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_s2mm_bytewriter #(
    .COUNT (COUNT),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .done          (done),
    .err_early_last(err_early_last),
    .err_no_last   (err_no_last),
    .beat_count    (beat_count)
  );

  // Observation of handshakes, sampled mid-cycle.
  logic [39:0] obs_q[$];
  logic [7:0]  stim [0:39];
  int          cyc = 0;
  int          beats_seen, done_cnt, done_cyc, last_wr_cyc, first_wr_cyc;
  int          hold_viol, tready_viol;
  logic        stall_q;
  logic [31:0] stall_addr;
  logic [7:0]  stall_data;

  always @(negedge clk) begin
    cyc++;
    if (stall_q && (!wr_en || wr_addr !== stall_addr || wr_data !== stall_data)) hold_viol++;
    stall_q    = wr_en && !wr_ready;
    stall_addr = wr_addr;
    stall_data = wr_data;
    if (wr_en && !wr_ready && s_axis_tready) tready_viol++;
    if (s_axis_tvalid && s_axis_tready) beats_seen++;
    if (wr_en && wr_ready) begin
      obs_q.push_back({wr_addr, wr_data});
      if (obs_q.size() == 1) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wr_en0"}, wr_en, 0);
    chk({name, "_wr_addr0"}, wr_addr, 0);
    chk({name, "_wr_data0"}, wr_data, 0);
    chk({name, "_busy0"}, busy, 0);
    chk({name, "_done0"}, done, 0);
    chk({name, "_tready0"}, s_axis_tready, 0);
    chk({name, "_errs0"}, {err_early_last, err_no_last}, 0);
    chk({name, "_beat_count0"}, beat_count, 0);
  endtask

  // offer   : bytes presented on the stream
  // last_i  : index carrying tlast (-1 = none)
  // rmode   : 0 wr_ready=1, 1 pattern 1,0,0,1, 2 random
  // rst_at  : assert reset once this many beats are accepted (-1 = never)
  task automatic run_xfer(input string name, input logic [31:0] base, input int offer,
                          input int last_i, input int rmode, input bit gap_en,
                          input int rst_at);
    int          k, budget, post;
    bit          acc, seen_done;
    logic [39:0] exp_q[$];
    bit          exp_early, exp_no;
    int          n;

    for (int i = 0; i < 40; i++) stim[i] = 8'($urandom);
    obs_q.delete();
    beats_seen = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; first_wr_cyc = -1;
    hold_viol = 0; tready_viol = 0; stall_q = 1'b0;

    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_after_start"}, busy, 1);

    k = 0; budget = 0; post = 0; seen_done = 0;
    while (post < 3 && budget < 400) begin
      if (!s_axis_tvalid && k < offer && (!gap_en || $urandom_range(0, 2) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = stim[k];
        s_axis_tlast  = (k == last_i);
      end
      case (rmode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = (budget % 4 == 0) || (budget % 4 == 3);
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      if (done) seen_done = 1;
      if (seen_done) post++;
      @(posedge clk); #1;
      if (acc) begin
        s_axis_tvalid = 1'b0;
        k++;
      end
      budget++;
      if (rst_at >= 0 && k == rst_at) break;
    end

    if (rst_at >= 0) begin
      // Asynchronous reset mid-transfer, away from any clock edge.
      #1 rst = 1'b1;
      #1;
      chk_all_zero({name, "_rst"});
      s_axis_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk({name, "_no_done_after_rst"}, done_cnt, 0);
      rst = 1'b0;
      return;
    end

    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk({name, "_no_timeout"}, budget < 400, 1);

    // Reference: walk the offered stream until the final slot or a tlast.
    exp_early = 0; exp_no = 0;
    for (int i = 0; i < offer; i++) begin
      exp_q.push_back({base + 32'(i), stim[i]});
      if (i == int'(COUNT) - 1) begin
        exp_no = (i != last_i);
        break;
      end
      if (i == last_i) begin
        exp_early = 1;
        break;
      end
    end

    chk({name, "_n_writes"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_write%0d", name, i), obs_q[i], exp_q[i]);
    chk({name, "_beats_accepted"}, beats_seen, exp_q.size());
    chk({name, "_beat_count"}, beat_count, exp_q.size());
    chk({name, "_err_early_last"}, err_early_last, exp_early);
    chk({name, "_err_no_last"}, err_no_last, exp_no);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_done_timing"}, done_cyc, last_wr_cyc + 1);
    chk({name, "_hold_stable"}, hold_viol, 0);
    chk({name, "_tready_when_stalled"}, tready_viol, 0);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_tready_end"}, s_axis_tready, 0);
    if (rmode == 0 && !gap_en)
      chk({name, "_throughput"}, last_wr_cyc - first_wr_cyc, exp_q.size() - 1);
  endtask

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    wr_ready      = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_xfer("basic",     32'h0000_0000, 32, 31, 0, 0, -1);
    run_xfer("backpress", 32'h0000_0000, 32, 31, 1, 1, -1);
    run_xfer("early",     32'h0000_0000, 32,  9, 2, 0, -1);
    run_xfer("nolast",    32'h0000_0000, 33, -1, 0, 1, -1);
    run_xfer("wrap",      32'hFFFF_FFF0, 32, 31, 2, 1, -1);
    run_xfer("abort",     32'h0000_0100, 32, 31, 0, 0, 12);
    run_xfer("after_rst", 32'h0000_0200, 32, 31, 0, 0, -1);
    for (int r = 0; r < 3; r++)
      run_xfer($sformatf("rand%0d", r), $urandom, 34, $urandom_range(0, 33), 2, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
